vga_buf_arbiter: RTL and testbench
==================================

// Module: vga_buf_arbiter
// PURPOSE
//  Shares the single write port of the VGA pixel BRAM (640x480x8) between the rangefinder plotter (req0) and the
//  disparity result writer (req1), replacing the static sw-driven write mux. Also sequences frame clears on reset,
//  on request and on display-mode change. Sits in mqp_top between the producers and BRAM port A, on clk_100M.
// PARAMETERS
//  ADDR_W      19      BRAM address width
//  DATA_W      8       pixel width
//  FRAME_WORDS 307200  words cleared per frame clear (640*480)
//  CLEAR_VAL   8'h00   value written during clear
// PORTS
//  clk         in  1       100MHz clock; sole clock domain
//  reset       in  1       asynchronous, active-low reset
//  mode        in  2       00 req0 only, 01 req1 only, 10 both round-robin, 11 = 10
//  clear_start in  1       one-cycle pulse: start/restart frame clear
//  r0_valid    in  1       req0 write request
//  r0_ready    out 1       req0 accept
//  r0_addr     in  ADDR_W  req0 pixel address
//  r0_data     in  DATA_W  req0 pixel data
//  r1_valid/r1_ready/r1_addr/r1_data   as req0, for req1
//  bram_en     out 1       port A enable (wea tied high at top level)
//  bram_addr   out ADDR_W  port A address
//  bram_din    out DATA_W  port A write data
//  clear_busy  out 1       clear in progress
//  clear_done  out 1       one-cycle pulse when last clear write issues
// BEHAVIOUR
//  - Reset values: bram_en=0, bram_addr=0, bram_din=0, clear_done=0, clear_busy=1, r*_ready=0. State=CLEAR,
//    clear_addr=0. Reset takes effect immediately, including mid-clear or mid-transfer; releases into CLEAR.
//  - States: CLEAR -> ARB when the write at FRAME_WORDS-1 issues. ARB -> CLEAR on clear_start, or when mode
//    differs from the mode registered on the previous cycle. clear_start in CLEAR restarts at address 0.
//  - CLEAR: one write per cycle, addr 0..FRAME_WORDS-1, data CLEAR_VAL. Both r*_ready=0. clear_busy=1.
//    clear_done asserts on the cycle the FRAME_WORDS-1 write is registered; clear_busy drops on the same edge.
//  - ARB: transfer on valid&&ready. r*_ready is combinational from state, mode, valids and last-grant pointer;
//    producers must not derive valid from ready.
//    Enabled requester: ready=1 when it is the grant. A disabled requester (by mode) gets ready=1 whenever in ARB
//    (sink), and its data is dropped and never reaches the BRAM.
//    Both enabled and valid: grant the one not granted last. Pointer updates only on an actual grant.
//    Pointer resets to req1-last, so req0 wins the first tie.
//  - Latency: an accepted transfer appears on bram_en/addr/din on the next cycle (single register stage).
//    Max one BRAM write per cycle. bram_en=0 in any cycle with no transfer.
//  - Simultaneous clear_start and accepted transfer: the transfer has been accepted and still issues next cycle.
//    The clear begins the cycle after that.
//  - Addresses are passed unchecked. Upstream computes 640-stride (rangefinder) or 384-stride (disparity).
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs r0_wr_cnt, r1_wr_cnt, r0_drop_cnt, r1_drop_cnt (16 bits each).
//   - The counters saturate at 16'hFFFF. A drop is a transfer accepted while the requester is disabled.
//   - All counters reset asynchronously and clear on clear_start; in debug mode they are shown on leds.
//  ARB_STATS_EN undefined: no counters, no ports; the arbitration logic is otherwise identical.
// STRUCTURE
//  Package vga_buf_pkg: mode encodings (MODE_RF, MODE_DISP, MODE_BOTH), state enum (ST_CLEAR, ST_ARB),
//  VGA_FRAME_WORDS=307200, DISP_FRAME_WORDS=110592.
//  Sub-module vga_clear_seq: clear address counter plus the done/busy flags. The arbiter and output register stay
//  in the top.
// TESTING
//  1 Reset release: bram_en high for 307200 cycles, addr 0..307199, data 00. clear_done pulses on 307199.
//    r*_ready=0 throughout.
//  2 mode=10, r0 and r1 valid every cycle (r0 addr 10.., r1 addr 5000..): grants alternate r0,r1,r0.
//    Each write appears one cycle after its accept; there are no gaps or duplicates.
//  3 mode=00, r1 streams 100 writes: r1_ready=1 and no r1 address reaches the BRAM.
//    With ARB_STATS_EN, r1_drop_cnt=100.
//  4 Change mode 00->01 mid-stream: clear_busy rises the next cycle and both readies drop.
//    The full clear runs, then r1 is served.
//  5 clear_start at clear address 1000: the clear restarts at 0. Pull reset low mid-clear: outputs return to their
//    reset values immediately.
//  6 Tie right after reset, with both requesters valid on the first ARB cycle: req0 is granted first.

Source files
------------

// File: rtl/vga_buf_pkg.sv
// Shared definitions for the VGA pixel-BRAM write arbiter.
// Contents: display-mode encodings, arbiter state encodings, frame sizes and small helpers.
package vga_buf_pkg;

    localparam logic [1:0] MODE_RF   = 2'b00;  // rangefinder plotter only
    localparam logic [1:0] MODE_DISP = 2'b01;  // disparity writer only
    localparam logic [1:0] MODE_BOTH = 2'b10;  // both, round-robin (2'b11 behaves the same)

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;

    localparam int unsigned VGA_FRAME_WORDS  = 307200;  // 640*480
    localparam int unsigned DISP_FRAME_WORDS = 110592;  // 384*288

    // req0 is served in every mode except disparity-only.
    function automatic logic mode_en0(input logic [1:0] mode);
        return mode != MODE_DISP;
    endfunction

    // req1 is served in every mode except rangefinder-only.
    function automatic logic mode_en1(input logic [1:0] mode);
        return mode != MODE_RF;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/vga_clear_seq.sv
// Frame-clear sequencer: address counter plus busy/done flags.
// Ports:
//   clk_i, reset_ni  clock, asynchronous active-low reset
//   active_i         arbiter is in the clear state; one clear write issues this cycle
//   restart_i        restart the clear at address 0 (this cycle issues address 0)
//   enter_i          arbiter leaves ARB for CLEAR at the next edge
//   issue_addr_o     address of the clear write issued this cycle
//   last_o           this cycle issues the final frame word
//   busy_o, done_o   registered clear-in-progress flag and one-cycle completion pulse
module vga_clear_seq
    import vga_buf_pkg::*;
#(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned FRAME_WORDS = VGA_FRAME_WORDS
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              active_i,
    input  logic              restart_i,
    input  logic              enter_i,
    output logic [ADDR_W-1:0] issue_addr_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_WORDS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        issue_addr_o = restart_i ? '0 : addr_q;
        last_o       = active_i && (issue_addr_o == LastAddr);
        // Counter idles at zero outside a clear so every clear starts from address 0.
        addr_d       = '0;
        if (active_i && !last_o) begin
            addr_d = issue_addr_o + ADDR_W'(1);
        end
        busy_d = enter_i || (active_i && !last_o);
        done_d = last_o;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_q <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/vga_buf_arbiter.sv
// Shares the VGA pixel-BRAM write port between the rangefinder plotter (req0) and the disparity
// writer (req1), and sequences frame clears on reset, on clear_start_i and on mode change.
// Ports:
//   clk_i, reset_ni               100 MHz clock, asynchronous active-low reset
//   mode_i                        00 req0 only, 01 req1 only, 1x both round-robin
//   clear_start_i                 one-cycle pulse: start/restart a frame clear
//   r{0,1}_valid_i/ready_o/addr_i/data_i   write request handshakes
//   bram_en_o/addr_o/din_o        registered BRAM port A write
//   clear_busy_o, clear_done_o    clear in progress, pulse on final clear write
// Optional: define ARB_STATS_EN to add saturating 16-bit write/drop counters per requester.
module vga_buf_arbiter
    import vga_buf_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 19,
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        FRAME_WORDS = VGA_FRAME_WORDS,
    parameter logic [DATA_W-1:0]  CLEAR_VAL   = '0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [1:0]        mode_i,
    input  logic              clear_start_i,
    input  logic              r0_valid_i,
    output logic              r0_ready_o,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_data_i,
    input  logic              r1_valid_i,
    output logic              r1_ready_o,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_data_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    output logic              clear_busy_o,
    output logic              clear_done_o
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       r0_wr_cnt_o,
    output logic [15:0]       r1_wr_cnt_o,
    output logic [15:0]       r0_drop_cnt_o,
    output logic [15:0]       r1_drop_cnt_o
`endif
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        mode_q;
    logic              last1_q, last1_d;  // 1: req1 was granted last
    logic              bram_en_q, bram_en_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;

    logic              in_arb, en0, en1, gnt0, gnt1, enter_clr, restart_clr;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;

    always_comb begin
        in_arb      = (state_q == ST_ARB);
        en0         = mode_en0(mode_i);
        en1         = mode_en1(mode_i);
        // On a tie the requester not granted last wins.
        gnt0        = in_arb && en0 && r0_valid_i && (!(en1 && r1_valid_i) || last1_q);
        gnt1        = in_arb && en1 && r1_valid_i && (!(en0 && r0_valid_i) || !last1_q);
        // A disabled requester is always accepted in ARB and its data discarded.
        r0_ready_o  = gnt0 || (in_arb && !en0);
        r1_ready_o  = gnt1 || (in_arb && !en1);
        enter_clr   = in_arb && (clear_start_i || (mode_i != mode_q));
        restart_clr = !in_arb && clear_start_i;

        state_d = state_q;
        if (!in_arb && clr_last) begin
            state_d = ST_ARB;
        end else if (enter_clr) begin
            state_d = ST_CLEAR;
        end

        last1_d = last1_q;
        if (gnt0) begin
            last1_d = 1'b0;
        end else if (gnt1) begin
            last1_d = 1'b1;
        end

        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        if (!in_arb) begin
            bram_en_d   = 1'b1;
            bram_addr_d = clr_addr;
            bram_din_d  = CLEAR_VAL;
        end else if (gnt0) begin
            bram_en_d   = 1'b1;
            bram_addr_d = r0_addr_i;
            bram_din_d  = r0_data_i;
        end else if (gnt1) begin
            bram_en_d   = 1'b1;
            bram_addr_d = r1_addr_i;
            bram_din_d  = r1_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_CLEAR;
            mode_q      <= MODE_RF;
            last1_q     <= 1'b1;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_i;
            last1_q     <= last1_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
        end
    end

    vga_clear_seq #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_clear_seq (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .active_i     (!in_arb),
        .restart_i    (restart_clr),
        .enter_i      (enter_clr),
        .issue_addr_o (clr_addr),
        .last_o       (clr_last),
        .busy_o       (clear_busy_o),
        .done_o       (clear_done_o)
    );

    assign bram_en_o   = bram_en_q;
    assign bram_addr_o = bram_addr_q;
    assign bram_din_o  = bram_din_q;

`ifdef ARB_STATS_EN
    logic [15:0] r0_wr_q, r1_wr_q, r0_drop_q, r1_drop_q;
    logic        drop0, drop1;

    assign drop0 = in_arb && !en0 && r0_valid_i;
    assign drop1 = in_arb && !en1 && r1_valid_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r0_wr_q   <= '0;
            r1_wr_q   <= '0;
            r0_drop_q <= '0;
            r1_drop_q <= '0;
        end else if (clear_start_i) begin
            r0_wr_q   <= '0;
            r1_wr_q   <= '0;
            r0_drop_q <= '0;
            r1_drop_q <= '0;
        end else begin
            if (gnt0)  r0_wr_q   <= sat_inc16(r0_wr_q);
            if (gnt1)  r1_wr_q   <= sat_inc16(r1_wr_q);
            if (drop0) r0_drop_q <= sat_inc16(r0_drop_q);
            if (drop1) r1_drop_q <= sat_inc16(r1_drop_q);
        end
    end

    assign r0_wr_cnt_o   = r0_wr_q;
    assign r1_wr_cnt_o   = r1_wr_q;
    assign r0_drop_cnt_o = r0_drop_q;
    assign r1_drop_cnt_o = r1_drop_q;
`endif

endmodule

// File: tb/tb_vga_buf_arbiter.sv
// Directed bench for vga_buf_arbiter with a 64-word frame so full clears stay short.
module tb_vga_buf_arbiter;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FW     = 64;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic [1:0]        mode_i;
    logic              clear_start_i;
    logic              r0_valid_i, r1_valid_i;
    logic              r0_ready_o, r1_ready_o;
    logic [ADDR_W-1:0] r0_addr_i, r1_addr_i;
    logic [DATA_W-1:0] r0_data_i, r1_data_i;
    logic              bram_en_o;
    logic [ADDR_W-1:0] bram_addr_o;
    logic [DATA_W-1:0] bram_din_o;
    logic              clear_busy_o, clear_done_o;
`ifdef ARB_STATS_EN
    logic [15:0]       r0_wr_cnt_o, r1_wr_cnt_o, r0_drop_cnt_o, r1_drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    vga_buf_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FRAME_WORDS (FW),
        .CLEAR_VAL   (8'h00)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .mode_i        (mode_i),
        .clear_start_i (clear_start_i),
        .r0_valid_i    (r0_valid_i),
        .r0_ready_o    (r0_ready_o),
        .r0_addr_i     (r0_addr_i),
        .r0_data_i     (r0_data_i),
        .r1_valid_i    (r1_valid_i),
        .r1_ready_o    (r1_ready_o),
        .r1_addr_i     (r1_addr_i),
        .r1_data_i     (r1_data_i),
        .bram_en_o     (bram_en_o),
        .bram_addr_o   (bram_addr_o),
        .bram_din_o    (bram_din_o),
        .clear_busy_o  (clear_busy_o),
        .clear_done_o  (clear_done_o)
`ifdef ARB_STATS_EN
        ,
        .r0_wr_cnt_o   (r0_wr_cnt_o),
        .r1_wr_cnt_o   (r1_wr_cnt_o),
        .r0_drop_cnt_o (r0_drop_cnt_o),
        .r1_drop_cnt_o (r1_drop_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 ns after the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " en"}, 32'(bram_en_o), 32'd0);
        chk({tag, " addr"}, 32'(bram_addr_o), 32'd0);
        chk({tag, " din"}, 32'(bram_din_o), 32'd0);
        chk({tag, " done"}, 32'(clear_done_o), 32'd0);
        chk({tag, " busy"}, 32'(clear_busy_o), 32'd1);
        chk({tag, " rdy0"}, 32'(r0_ready_o), 32'd0);
        chk({tag, " rdy1"}, 32'(r1_ready_o), 32'd0);
    endtask

    task automatic run_clear(input string tag);
        for (int i = 0; i < int'(FW); i++) begin
            tick();
            chk({tag, " en"}, 32'(bram_en_o), 32'd1);
            chk({tag, " addr"}, 32'(bram_addr_o), 32'(i));
            chk({tag, " done"}, 32'(clear_done_o), 32'(i == int'(FW) - 1));
        end
    endtask

    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_din;
    logic              g;

    initial begin
        reset_ni      = 1'b0;
        mode_i        = 2'b10;
        clear_start_i = 1'b0;
        r0_valid_i    = 1'b1;
        r0_addr_i     = 19'd10;
        r0_data_i     = 8'hA5;
        r1_valid_i    = 1'b1;
        r1_addr_i     = 19'd5000;
        r1_data_i     = 8'h5A;

        repeat (3) tick();
        chk_reset_vals("reset");

        // Reset release into a full clear; both requesters held valid to test the first tie.
        reset_ni = 1'b1;
        for (int i = 0; i < int'(FW); i++) begin
            tick();
            chk("clr0 en", 32'(bram_en_o), 32'd1);
            chk("clr0 addr", 32'(bram_addr_o), 32'(i));
            chk("clr0 din", 32'(bram_din_o), 32'h00);
            chk("clr0 done", 32'(clear_done_o), 32'(i == int'(FW) - 1));
            chk("clr0 busy", 32'(clear_busy_o), 32'(i != int'(FW) - 1));
            #1;
            chk("clr0 rdy0", 32'(r0_ready_o), 32'(i == int'(FW) - 1));
            chk("clr0 rdy1", 32'(r1_ready_o), 32'd0);
        end

        // Round-robin: 10, 5000, 11, 5001, 12, 5002.
        pend_addr = 19'd10;
        pend_din  = 8'hA5;
        g         = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr en", 32'(bram_en_o), 32'd1);
            chk("rr addr", 32'(bram_addr_o), 32'(pend_addr));
            chk("rr din", 32'(bram_din_o), 32'(pend_din));
            chk("rr done", 32'(clear_done_o), 32'd0);
            if (g == 1'b0) r0_addr_i = r0_addr_i + 19'd1;
            else           r1_addr_i = r1_addr_i + 19'd1;
            g = ~g;
            #1;
            chk("rr rdy0", 32'(r0_ready_o), 32'(g == 1'b0));
            chk("rr rdy1", 32'(r1_ready_o), 32'(g == 1'b1));
            pend_addr = (g == 1'b0) ? r0_addr_i : r1_addr_i;
            pend_din  = (g == 1'b0) ? r0_data_i : r1_data_i;
        end

        // Mode 10 -> 00 with no traffic: a clear must run.
        r0_valid_i = 1'b0;
        r1_valid_i = 1'b0;
        mode_i     = 2'b00;
        tick();
        chk("m00 en", 32'(bram_en_o), 32'd0);
        chk("m00 busy", 32'(clear_busy_o), 32'd1);
        run_clear("clr1");

        // Mode 00: r1 is sunk, 100 drops never reach the BRAM.
        r1_valid_i = 1'b1;
        r1_addr_i  = 19'd9000;
        #1;
        chk("sink rdy1", 32'(r1_ready_o), 32'd1);
        chk("sink rdy0", 32'(r0_ready_o), 32'd0);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k == 99) r1_valid_i = 1'b0;
            else         r1_addr_i  = r1_addr_i + 19'd1;
            chk("sink en", 32'(bram_en_o), 32'd0);
        end
        tick();
        chk("sink tail en", 32'(bram_en_o), 32'd0);
`ifdef ARB_STATS_EN
        chk("stat r1 drop", 32'(r1_drop_cnt_o), 32'd100);
        chk("stat r0 drop", 32'(r0_drop_cnt_o), 32'd0);
        chk("stat r0 wr", 32'(r0_wr_cnt_o), 32'd3);
        chk("stat r1 wr", 32'(r1_wr_cnt_o), 32'd3);
`endif

        // r0 streams in mode 00, then mode switches to 01 mid-stream.
        r0_valid_i = 1'b1;
        r0_addr_i  = 19'd200;
        r0_data_i  = 8'h11;
        #1;
        chk("m00 rdy0", 32'(r0_ready_o), 32'd1);
        tick();
        chk("m00 w0 addr", 32'(bram_addr_o), 32'd200);
        chk("m00 w0 en", 32'(bram_en_o), 32'd1);
        r0_addr_i = 19'd201;
        tick();
        chk("m00 w1 addr", 32'(bram_addr_o), 32'd201);
        chk("m00 w1 din", 32'(bram_din_o), 32'h11);
        r0_addr_i = 19'd202;
        mode_i    = 2'b01;
        #1;
        chk("m01 sink rdy0", 32'(r0_ready_o), 32'd1);
        chk("m01 rdy1", 32'(r1_ready_o), 32'd0);
        tick();
        chk("m01 drop en", 32'(bram_en_o), 32'd0);
        chk("m01 busy", 32'(clear_busy_o), 32'd1);
        #1;
        chk("m01 clr rdy0", 32'(r0_ready_o), 32'd0);
        chk("m01 clr rdy1", 32'(r1_ready_o), 32'd0);
        r0_valid_i = 1'b0;
        run_clear("clr2");
        r1_valid_i = 1'b1;
        r1_addr_i  = 19'd7000;
        r1_data_i  = 8'h77;
        #1;
        chk("m01 rdy1", 32'(r1_ready_o), 32'd1);
        tick();
        r1_valid_i = 1'b0;
        chk("m01 w en", 32'(bram_en_o), 32'd1);
        chk("m01 w addr", 32'(bram_addr_o), 32'd7000);
        chk("m01 w din", 32'(bram_din_o), 32'h77);

        // clear_start from ARB, then restart mid-clear at address 20.
        clear_start_i = 1'b1;
        tick();
        clear_start_i = 1'b0;
        chk("cs en", 32'(bram_en_o), 32'd0);
        chk("cs busy", 32'(clear_busy_o), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("cs addr", 32'(bram_addr_o), 32'(i));
        end
        clear_start_i = 1'b1;
        tick();
        clear_start_i = 1'b0;
        chk("restart addr", 32'(bram_addr_o), 32'd0);
        chk("restart en", 32'(bram_en_o), 32'd1);
        tick();
        chk("restart addr1", 32'(bram_addr_o), 32'd1);
        tick();
        chk("restart addr2", 32'(bram_addr_o), 32'd2);
        chk("restart busy", 32'(clear_busy_o), 32'd1);
`ifdef ARB_STATS_EN
        chk("stat cleared", 32'(r1_drop_cnt_o), 32'd0);
`endif

        // Asynchronous reset mid-clear, away from the clock edge.
        #2;
        reset_ni = 1'b0;
        #1;
        chk_reset_vals("async rst");
        repeat (2) tick();
        reset_ni = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
